// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin / fixed-priority arbiter.
// Holds the FSM state encoding and the rr_mode values.
package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner pick: LSB-first priority over a double-width vector whose
// lower half is req masked to bits at/above rr_ptr (round-robin) or all of req (fixed).
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N_REQ = 8,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             rr_mode,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             found
);

    logic [N_REQ-1:0]   mask;
    logic [2*N_REQ-1:0] dbl;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = (rr_mode == ARB_RR) ? (i >= int'(rr_ptr)) : 1'b1;
        end
        dbl = {req, req & mask};

        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        // Downward scan so the lowest set bit is the last one assigned.
        for (int i = 2*N_REQ-1; i >= 0; i--) begin
            if (dbl[i]) begin
                found      = 1'b1;
                winner_idx = IDX_W'(i % N_REQ);
                winner     = {{(N_REQ-1){1'b0}}, 1'b1} << (i % N_REQ);
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter with registered, held grant; fixed-priority or round-robin pick,
// released when the winner drops its request or after MAX_HOLD cycles.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = 8,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_mode,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             any_req,
    output logic             hold_timeout
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             hold_timeout_q, hold_timeout_d;

    logic [N_REQ-1:0] pick_winner;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             owner_req;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .rr_mode    (rr_mode),
        .winner     (pick_winner),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );

    assign owner_req = req[grant_idx_q];

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        grant_idx_d    = grant_idx_q;
        hold_cnt_d     = hold_cnt_q;
        rr_ptr_d       = rr_ptr_q;
        hold_timeout_d = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d     = ARB_GRANT;
                    grant_d     = pick_winner;
                    grant_idx_d = pick_idx;
                    hold_cnt_d  = '0;
                end
            end
            ARB_GRANT: begin
                if (!owner_req || hold_cnt_q == HOLD_LAST) begin
                    // A drop on the last hold cycle counts as a normal release.
                    hold_timeout_d = owner_req;
                    state_d        = ARB_IDLE;
                    grant_d        = '0;
                    grant_idx_d    = '0;
                    hold_cnt_d     = '0;
                    rr_ptr_d       = (grant_idx_q == IDX_LAST) ? '0
                                                               : grant_idx_q + IDX_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ARB_IDLE;
            grant_q        <= '0;
            grant_idx_q    <= '0;
            hold_cnt_q     <= '0;
            rr_ptr_q       <= '0;
            hold_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            grant_idx_q    <= grant_idx_d;
            hold_cnt_q     <= hold_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    assign grant        = grant_q;
    assign grant_idx    = grant_idx_q;
    assign grant_valid  = (state_q == ARB_GRANT);
    assign hold_timeout = hold_timeout_q;
    assign any_req      = |req;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter: three instances (8/16, 8/4, 5/16)
// driven with hand-computed cycle-by-cycle expectations.
module tb_rr_priority_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N_REQ=8, MAX_HOLD=16
    logic       rst_a, mode_a;
    logic [7:0] req_a, grant_a;
    logic [2:0] idx_a;
    logic       gv_a, any_a, to_a;

    // Instance B: N_REQ=8, MAX_HOLD=4
    logic       rst_b, mode_b;
    logic [7:0] req_b, grant_b;
    logic [2:0] idx_b;
    logic       gv_b, any_b, to_b;

    // Instance C: N_REQ=5, MAX_HOLD=16
    logic       rst_c, mode_c;
    logic [4:0] req_c, grant_c;
    logic [2:0] idx_c;
    logic       gv_c, any_c, to_c;

    rr_priority_arbiter #(.N_REQ(8), .MAX_HOLD(16)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .rr_mode(mode_a),
        .grant(grant_a), .grant_idx(idx_a), .grant_valid(gv_a),
        .any_req(any_a), .hold_timeout(to_a)
    );

    rr_priority_arbiter #(.N_REQ(8), .MAX_HOLD(4)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .rr_mode(mode_b),
        .grant(grant_b), .grant_idx(idx_b), .grant_valid(gv_b),
        .any_req(any_b), .hold_timeout(to_b)
    );

    rr_priority_arbiter #(.N_REQ(5), .MAX_HOLD(16)) dut_c (
        .clk(clk), .rst(rst_c), .req(req_c), .rr_mode(mode_c),
        .grant(grant_c), .grant_idx(idx_c), .grant_valid(gv_c),
        .any_req(any_c), .hold_timeout(to_c)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_q[$];

    int         fix_w[3] = '{2, 5, 7};
    logic [7:0] fix_n[3] = '{8'hA0, 8'h80, 8'h00};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic gv, input int idx, input logic to);
        check_eq({tag, " gv"},    32'(gv_a),    32'(gv));
        check_eq({tag, " idx"},   32'(idx_a),   gv ? 32'(idx) : 32'd0);
        check_eq({tag, " grant"}, 32'(grant_a), gv ? (32'd1 << idx) : 32'd0);
        check_eq({tag, " to"},    32'(to_a),    32'(to));
    endtask

    task automatic chk_b(input string tag, input logic gv, input int idx, input logic to);
        check_eq({tag, " gv"},    32'(gv_b),    32'(gv));
        check_eq({tag, " idx"},   32'(idx_b),   gv ? 32'(idx) : 32'd0);
        check_eq({tag, " grant"}, 32'(grant_b), gv ? (32'd1 << idx) : 32'd0);
        check_eq({tag, " to"},    32'(to_b),    32'(to));
    endtask

    task automatic chk_c(input string tag, input logic gv, input int idx, input logic to);
        check_eq({tag, " gv"},    32'(gv_c),    32'(gv));
        check_eq({tag, " idx"},   32'(idx_c),   gv ? 32'(idx) : 32'd0);
        check_eq({tag, " grant"}, 32'(grant_c), gv ? (32'd1 << idx) : 32'd0);
        check_eq({tag, " to"},    32'(to_c),    32'(to));
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        logic [31:0] e;

        // Reset
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        req_a = '0;   req_b = '0;   req_c = '0;
        mode_a = 1'b0; mode_b = 1'b1; mode_c = 1'b1;
        step();
        step();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        chk_a("reset a", 1'b0, 0, 1'b0);
        chk_b("reset b", 1'b0, 0, 1'b0);
        chk_c("reset c", 1'b0, 0, 1'b0);
        check_eq("reset any_a", 32'(any_a), 32'd0);

        // Fixed priority: 2, 5, 7 with one-cycle latency and bubbles
        req_a = 8'hA4;
        check_eq("fix any_a", 32'(any_a), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_a("fix grant", 1'b1, fix_w[k], 1'b0);
            step();
            chk_a("fix hold", 1'b1, fix_w[k], 1'b0);
            req_a = fix_n[k];
            step();
            chk_a("fix bubble", 1'b0, 0, 1'b0);
        end
        check_eq("fix any_a idle", 32'(any_a), 32'd0);

        // Move rr_ptr to 5, then reset mid-grant must clear it back to 0
        req_a = 8'h10;
        step();
        chk_a("ptr grant", 1'b1, 4, 1'b0);
        req_a = 8'h00;
        step();
        chk_a("ptr release", 1'b0, 0, 1'b0);
        req_a = 8'h10;
        step();
        chk_a("pre rst grant", 1'b1, 4, 1'b0);
        rst_a = 1'b1;
        step();
        chk_a("rst mid grant", 1'b0, 0, 1'b0);
        rst_a = 1'b0;
        req_a = 8'h00;
        step();
        chk_a("idle after rst", 1'b0, 0, 1'b0);
        check_eq("idle any_a", 32'(any_a), 32'd0);
        step();
        chk_a("idle again", 1'b0, 0, 1'b0);

        // Round-robin fairness: 0..7 then wrap to 0 (pointer starts at 0 after reset)
        mode_a = 1'b1;
        req_a  = 8'hFF;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
        exp_q.push_back(32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            chk_a("rr grant", 1'b1, int'(e), 1'b0);
            req_a = 8'hFF & ~(8'd1 << e);
            step();
            chk_a("rr bubble", 1'b0, 0, 1'b0);
            req_a = 8'hFF;
        end

        // Mode change during grant (rr_ptr is 1 here)
        req_a = 8'h0D;
        step();
        chk_a("mc rr pick", 1'b1, 2, 1'b0);
        mode_a = 1'b0;
        step();
        chk_a("mc hold", 1'b1, 2, 1'b0);
        req_a = 8'h09;
        step();
        chk_a("mc release", 1'b0, 0, 1'b0);
        step();
        chk_a("mc fixed pick", 1'b1, 0, 1'b0);
        mode_a = 1'b1;
        step();
        chk_a("mc hold2", 1'b1, 0, 1'b0);
        req_a = 8'h08;
        step();
        chk_a("mc release2", 1'b0, 0, 1'b0);
        req_a = 8'h09;
        step();
        chk_a("mc rr pick2", 1'b1, 3, 1'b0);
        req_a = 8'h00;
        step();
        chk_a("mc end", 1'b0, 0, 1'b0);

        // Hold timeout with MAX_HOLD=4
        req_b = 8'h08;
        step();
        chk_b("to grant", 1'b1, 3, 1'b0);
        repeat (3) begin
            step();
            chk_b("to hold", 1'b1, 3, 1'b0);
        end
        step();
        chk_b("to pulse", 1'b0, 0, 1'b1);
        step();
        chk_b("to regrant", 1'b1, 3, 1'b0);
        req_b = 8'h04;
        step();
        chk_b("to drop", 1'b0, 0, 1'b0);
        req_b = 8'h0C;
        step();
        chk_b("to wrap pick", 1'b1, 2, 1'b0);
        repeat (3) begin
            step();
            chk_b("to hold2", 1'b1, 2, 1'b0);
        end
        step();
        chk_b("to pulse2", 1'b0, 0, 1'b1);
        step();
        chk_b("to rr next", 1'b1, 3, 1'b0);
        repeat (3) begin
            step();
            chk_b("to hold3", 1'b1, 3, 1'b0);
        end
        req_b = 8'h00;
        step();
        chk_b("simul drop", 1'b0, 0, 1'b0);
        step();
        chk_b("b idle", 1'b0, 0, 1'b0);

        // Non-power-of-2 wrap, N_REQ=5
        req_c = 5'b10001;
        exp_q = '{32'd0, 32'd4, 32'd0, 32'd4, 32'd0};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            chk_c("n5 grant", 1'b1, int'(e), 1'b0);
            req_c = 5'b10001 & ~(5'd1 << e);
            step();
            chk_c("n5 bubble", 1'b0, 0, 1'b0);
            req_c = 5'b10001;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
